pushsw_mode_sync: RTL and testbench

//  Input stage ahead of the ALU top: synchronises DIP_input, debounces the six push switches,
//  and holds the ALU operation select as a registered 3-bit mode (0..6) with a change strobe.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/pushsw_debounce.sv | 54 +++++
 rtl/pushsw_mode_sync.sv | 69 ++++++
 tb/tb_pushsw_mode_sync.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU input stage and display path.
// Also holds the push-switch priority helper.
package alu_pkg;

    localparam logic [2:0] MODE_NONE = 3'd7;
    localparam logic [2:0] MODE_OP5  = 3'd5;
    localparam logic [2:0] MODE_OP6  = 3'd6;
    localparam int NUM_OPS    = 7;
    localparam int NUM_PUSHSW = 6;
    localparam int DIP_W      = 10;

    // Lowest pressed index wins; MODE_NONE means nothing was pressed this cycle.
    function automatic logic [2:0] first_press(input logic [NUM_PUSHSW-1:0] press);
        first_press = MODE_NONE;
        for (int i = NUM_PUSHSW - 1; i >= 0; i--) begin
            if (press[i]) begin
                first_press = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/pushsw_debounce.sv
// One push switch: synchroniser, stability counter, debounced level and a
// single-cycle press pulse on each accepted released->pressed transition.
module pushsw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int PUSH_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic RELEASED_PIN = (PUSH_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   stable;
    logic                   level;
    logic                   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RELEASED_PIN}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign level  = (PUSH_ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    assign accept = (level != stable) && (cnt == CNT_LAST);

    // Press is registered alongside the stable flip so mode follows one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= accept & level;
            if (level == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= level;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pushsw_mode_sync.sv
// ALU input stage: synchronised DIP operands plus a debounced, registered
// operation select with a sticky valid flag and a per-press strobe.
module pushsw_mode_sync
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int PUSH_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIP_W-1:0]      DIP_input,
    input  logic [NUM_PUSHSW-1:0] PUSHSW_input,
    output logic [DIP_W-1:0]      dip_sync,
    output logic [2:0]            mode,
    output logic                  mode_valid,
    output logic                  mode_strobe
);

    logic [SYNC_STAGES-1:0][DIP_W-1:0] dip_q;
    logic [NUM_PUSHSW-1:0]             press;
    logic [2:0]                        sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dip_q <= '0;
        end else begin
            dip_q <= {dip_q[SYNC_STAGES-2:0], DIP_input};
        end
    end

    assign dip_sync = dip_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_PUSHSW; i++) begin : g_sw
        pushsw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .PUSH_ACTIVE_LOW(PUSH_ACTIVE_LOW)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .pin  (PUSHSW_input[i]),
            .press(press[i])
        );
    end

    assign sel = first_press(press);

    // SW5 toggles between operations 5 and 6; coincident presses beyond the winner are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= MODE_NONE;
            mode_valid  <= 1'b0;
            mode_strobe <= 1'b0;
        end else begin
            mode_strobe <= 1'b0;
            if (sel != MODE_NONE) begin
                mode_valid  <= 1'b1;
                mode_strobe <= 1'b1;
                if (sel == MODE_OP5) begin
                    mode <= (mode == MODE_OP5) ? MODE_OP6 : MODE_OP5;
                end else begin
                    mode <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_pushsw_mode_sync.sv
// Directed bench for pushsw_mode_sync with a short debounce window; inputs
// change and outputs are sampled 1 time unit after each rising clock edge.
module tb_pushsw_mode_sync;

    logic       clk;
    logic       rst;
    logic [9:0] DIP_input;
    logic [5:0] PUSHSW_input;
    logic [9:0] dip_sync;
    logic [2:0] mode;
    logic       mode_valid;
    logic       mode_strobe;

    int testsRun;
    int testsFailed;
    int strobeCount;
    int strobeMark;

    localparam logic [5:0] ALL_UP = 6'b111111;

    pushsw_mode_sync #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .PUSH_ACTIVE_LOW(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DIP_input   (DIP_input),
        .PUSHSW_input(PUSHSW_input),
        .dip_sync    (dip_sync),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .mode_strobe (mode_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mode_strobe) strobeCount++;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] pins, input logic [9:0] dip, input int n);
        PUSHSW_input = pins;
        DIP_input    = dip;
        waitClocks(n);
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        strobeCount  = 0;
        rst          = 1'b1;
        DIP_input    = '0;
        PUSHSW_input = ALL_UP;
        waitClocks(3);
        rst = 1'b0;
        waitClocks(2);

        // 1: reset state and DIP synchroniser latency
        checkOutput("reset_mode", 16'(mode), 16'd7);
        checkOutput("reset_valid", 16'(mode_valid), 16'd0);
        checkOutput("reset_strobe", 16'(mode_strobe), 16'd0);
        checkOutput("reset_dip", 16'(dip_sync), 16'd0);
        applyStimulus(ALL_UP, 10'h2A5, 1);
        checkOutput("dip_after1", 16'(dip_sync), 16'd0);
        waitClocks(1);
        checkOutput("dip_after2", 16'(dip_sync), 16'h2A5);

        // 2: clean SW2 press
        applyStimulus(6'b111011, 10'h2A5, 6);
        checkOutput("sw2_mode_at6", 16'(mode), 16'd7);
        checkOutput("sw2_strobe_at6", 16'(mode_strobe), 16'd0);
        waitClocks(1);
        checkOutput("sw2_mode_at7", 16'(mode), 16'd2);
        checkOutput("sw2_strobe_at7", 16'(mode_strobe), 16'd1);
        checkOutput("sw2_valid", 16'(mode_valid), 16'd1);
        waitClocks(1);
        checkOutput("sw2_strobe_at8", 16'(mode_strobe), 16'd0);
        waitClocks(2);
        applyStimulus(ALL_UP, 10'h2A5, 10);
        checkOutput("sw2_release_mode", 16'(mode), 16'd2);
        checkOutput("sw2_strobes", 16'(strobeCount), 16'd1);

        // 3: SW3 bouncing, then held
        strobeMark = strobeCount;
        for (int b = 0; b < 2; b++) begin
            applyStimulus(6'b110111, 10'h2A5, 2);
            applyStimulus(ALL_UP, 10'h2A5, 2);
        end
        applyStimulus(6'b110111, 10'h2A5, 6);
        checkOutput("sw3_mode_at6", 16'(mode), 16'd2);
        checkOutput("sw3_no_bounce_strobe", 16'(strobeCount - strobeMark), 16'd0);
        waitClocks(1);
        checkOutput("sw3_mode_at7", 16'(mode), 16'd3);
        checkOutput("sw3_strobe_at7", 16'(mode_strobe), 16'd1);
        waitClocks(3);
        applyStimulus(ALL_UP, 10'h2A5, 10);
        checkOutput("sw3_strobes", 16'(strobeCount - strobeMark), 16'd1);

        // 4: SW5 toggles 5 -> 6 -> 5
        strobeMark = strobeCount;
        applyStimulus(6'b011111, 10'h2A5, 7);
        checkOutput("sw5_first", 16'(mode), 16'd5);
        waitClocks(3);
        applyStimulus(ALL_UP, 10'h2A5, 10);
        applyStimulus(6'b011111, 10'h2A5, 7);
        checkOutput("sw5_second", 16'(mode), 16'd6);
        waitClocks(3);
        applyStimulus(ALL_UP, 10'h2A5, 10);
        applyStimulus(6'b011111, 10'h2A5, 7);
        checkOutput("sw5_third", 16'(mode), 16'd5);
        waitClocks(3);
        applyStimulus(ALL_UP, 10'h2A5, 10);
        checkOutput("sw5_strobes", 16'(strobeCount - strobeMark), 16'd3);

        // 5: SW1 and SW4 together, lowest index wins
        strobeMark = strobeCount;
        applyStimulus(6'b101101, 10'h2A5, 7);
        checkOutput("tie_mode", 16'(mode), 16'd1);
        waitClocks(10);
        checkOutput("tie_mode_later", 16'(mode), 16'd1);
        checkOutput("tie_strobes", 16'(strobeCount - strobeMark), 16'd1);
        applyStimulus(ALL_UP, 10'h2A5, 10);

        // 6: reset mid-debounce with SW0 held through deassertion
        applyStimulus(6'b111110, 10'h2A5, 4);
        rst = 1'b1;
        #1;
        checkOutput("rst_mode", 16'(mode), 16'd7);
        checkOutput("rst_valid", 16'(mode_valid), 16'd0);
        checkOutput("rst_strobe", 16'(mode_strobe), 16'd0);
        checkOutput("rst_dip", 16'(dip_sync), 16'd0);
        waitClocks(2);
        rst = 1'b0;
        waitClocks(6);
        checkOutput("sw0_mode_at6", 16'(mode), 16'd7);
        waitClocks(1);
        checkOutput("sw0_mode_at7", 16'(mode), 16'd0);
        checkOutput("sw0_strobe", 16'(mode_strobe), 16'd1);
        checkOutput("sw0_valid", 16'(mode_valid), 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
